// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the multiplexed
// seven-segment driver.
package seven_seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_t;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam int         PWM_LEVELS = 16;

   // Active-low g..a pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low segment decoder.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_segment_mux.sv
// N-digit multiplexed common-anode seven-segment driver with blanking gap,
// 16-level PWM brightness, per-digit blink and leading-zero suppression.
module seven_segment_mux
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DWELL_CYCLES = 25000,
   parameter int BLANK_CYCLES = 512,
   parameter int BLINK_FRAMES = 64
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] dataIn,
   input  logic [NUM_DIGITS-1:0]   digitDisplay,
   input  logic [NUM_DIGITS-1:0]   digitPoint,
   input  logic [NUM_DIGITS-1:0]   digitBlink,
   input  logic                    zeroSuppress,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              segment,
   output logic                    frameStart,
   output state_t                  dbg_state
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SLOT_W  = $clog2(DWELL_CYCLES);
   localparam int SUB_LEN = (DWELL_CYCLES - BLANK_CYCLES) / PWM_LEVELS;
   localparam int SUB_W   = $clog2(SUB_LEN + 1);
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DWELL_CYCLES - 1);
   localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_LEN - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
   localparam state_t             RST_STATE  = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   // Scan state
   logic [SLOT_W-1:0]  r_slot_cnt;
   logic [IDX_W-1:0]   r_digit_idx;
   state_t             r_state;
   logic [SUB_W-1:0]   r_sub_cnt;
   logic [3:0]         r_sub_idx;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic               r_blink_on;

   // Frame shadows
   logic [4*NUM_DIGITS-1:0] r_data;
   logic [NUM_DIGITS-1:0]   r_display;
   logic [NUM_DIGITS-1:0]   r_point;
   logic [NUM_DIGITS-1:0]   r_blink;
   logic                    r_zero_sup;
   logic [3:0]              r_bright;

   // Output registers
   logic [NUM_DIGITS-1:0] r_anode;
   logic [7:0]            r_segment;
   logic                  r_frame_start;

   logic                    w_slot_wrap;
   logic [SLOT_W-1:0]       w_slot_next;
   logic                    w_latch;
   logic [4*NUM_DIGITS-1:0] w_data;
   logic [NUM_DIGITS-1:0]   w_display;
   logic [NUM_DIGITS-1:0]   w_point;
   logic [NUM_DIGITS-1:0]   w_blink;
   logic                    w_zero_sup;
   logic [3:0]              w_bright;
   logic [NUM_DIGITS-1:0]   w_suppress;
   logic [NUM_DIGITS-1:0]   w_sel;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg;
   logic                    w_pwm_on;
   logic                    w_blink_off;
   logic                    w_drive;

   assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
   assign w_slot_next = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
   assign w_latch     = (r_slot_cnt == '0) && (r_digit_idx == '0);

   // The latch cycle itself must already see the freshly captured values,
   // so the shadows are bypassed while they are being loaded.
   assign w_data     = w_latch ? dataIn       : r_data;
   assign w_display  = w_latch ? digitDisplay : r_display;
   assign w_point    = w_latch ? digitPoint   : r_point;
   assign w_blink    = w_latch ? digitBlink   : r_blink;
   assign w_zero_sup = w_latch ? zeroSuppress : r_zero_sup;
   assign w_bright   = w_latch ? brightness   : r_bright;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= '0;
         r_state     <= RST_STATE;
         r_sub_cnt   <= '0;
         r_sub_idx   <= '0;
         r_frame_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else begin
         r_slot_cnt <= w_slot_next;
         if (w_slot_wrap) begin
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
         end
         r_state <= (w_slot_next < BLANK_END) ? BLANK : DRIVE;
         // Sub-slice 15 absorbs the leftover clocks, so it never advances.
         if (w_slot_next == BLANK_END) begin
            r_sub_cnt <= '0;
            r_sub_idx <= '0;
         end else if (r_state == DRIVE && r_sub_idx != 4'd15) begin
            if (r_sub_cnt == SUB_LAST) begin
               r_sub_cnt <= '0;
               r_sub_idx <= r_sub_idx + 1'b1;
            end else begin
               r_sub_cnt <= r_sub_cnt + 1'b1;
            end
         end
         if (w_slot_wrap && r_digit_idx == IDX_LAST) begin
            if (r_frame_cnt == FRAME_LAST) begin
               r_frame_cnt <= '0;
               r_blink_on  <= ~r_blink_on;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data     <= '0;
         r_display  <= '0;
         r_point    <= '0;
         r_blink    <= '0;
         r_zero_sup <= 1'b0;
         r_bright   <= '0;
      end else if (w_latch) begin
         r_data     <= dataIn;
         r_display  <= digitDisplay;
         r_point    <= digitPoint;
         r_blink    <= digitBlink;
         r_zero_sup <= zeroSuppress;
         r_bright   <= brightness;
      end
   end

   // A digit is suppressed when it and every more significant nibble are zero.
   always_comb begin
      logic zero_run;
      zero_run   = 1'b1;
      w_suppress = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (w_data[4*i +: 4] == 4'h0);
         if (i != 0) begin
            w_suppress[i] = zero_run & w_zero_sup;
         end
      end
   end

   always_comb begin
      w_sel              = '0;
      w_sel[r_digit_idx] = 1'b1;
   end

   assign w_nibble    = w_data[{r_digit_idx, 2'b00} +: 4];
   assign w_pwm_on    = (r_sub_idx <= w_bright);
   assign w_blink_off = ~r_blink_on & w_blink[r_digit_idx];
   assign w_drive     = (r_state == DRIVE) && w_display[r_digit_idx] &&
                        !w_suppress[r_digit_idx] && !w_blink_off && w_pwm_on;

   seven_seg_decoder u_decoder (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_anode       <= '1;
         r_segment     <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_latch;
         if (w_drive) begin
            r_anode   <= ~w_sel;
            r_segment <= {~w_point[r_digit_idx], w_seg};
         end else begin
            r_anode   <= '1;
            r_segment <= SEG_BLANK;
         end
      end
   end

   assign anode      = r_anode;
   assign segment    = r_segment;
   assign frameStart = r_frame_start;
   assign dbg_state  = r_state;

endmodule
